// File: rtl/noc_pkg.sv
// Shared router constants: port count, port index encoding and flit type field.
package noc_pkg;

  localparam int unsigned NUM_PORTS = 5;
  localparam int unsigned PORT_W    = 3;

  localparam logic [PORT_W-1:0] PORT_N = 3'd0;
  localparam logic [PORT_W-1:0] PORT_S = 3'd1;
  localparam logic [PORT_W-1:0] PORT_E = 3'd2;
  localparam logic [PORT_W-1:0] PORT_W_IDX = 3'd3;
  localparam logic [PORT_W-1:0] PORT_L = 3'd4;

  typedef enum logic [2:0] {
    FLIT_HEAD = 3'b000,
    FLIT_BODY = 3'b001,
    FLIT_TAIL = 3'b010
  } flit_type_e;

  localparam int unsigned FLIT_TYPE_HI = 57;
  localparam int unsigned FLIT_TYPE_LO = 55;

  // Round-robin successor of index w among n ports.
  function automatic int unsigned rr_next(input int unsigned w, input int unsigned n);
    return (w + 1 >= n) ? 0 : w + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr wins.
module rr_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned NUM_PORTS = noc_pkg::NUM_PORTS,
  parameter int unsigned PORT_W    = noc_pkg::PORT_W
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PORT_W-1:0]    ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [PORT_W-1:0]    idx
);

  int unsigned pos;
  logic        found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= NUM_PORTS) pos = pos - NUM_PORTS;
      if (!found && req[PORT_W'(pos)]) begin
        found                = 1'b1;
        gnt[PORT_W'(pos)]    = 1'b1;
        idx                  = PORT_W'(pos);
      end
    end
  end

endmodule

// File: rtl/switch_allocator.sv
// Packet-granular switch allocator: per-output round-robin with lock held
// from head flit until the tail flit is granted.
module switch_allocator
  import noc_pkg::*;
#(
  parameter int unsigned NUM_PORTS = noc_pkg::NUM_PORTS,
  parameter int unsigned PORT_W    = noc_pkg::PORT_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS*PORT_W-1:0] req_dest,
  input  logic [NUM_PORTS-1:0]        req_tail,
  input  logic [NUM_PORTS-1:0]        out_ready,
  output logic [NUM_PORTS-1:0]        grant,
  output logic [NUM_PORTS*PORT_W-1:0] xbar_sel,
  output logic [NUM_PORTS-1:0]        xbar_valid
);

  logic                 lock    [NUM_PORTS];
  logic [PORT_W-1:0]    owner   [NUM_PORTS];
  logic [PORT_W-1:0]    ptr     [NUM_PORTS];

  logic [NUM_PORTS-1:0] cand    [NUM_PORTS];
  logic [NUM_PORTS-1:0] arb_req [NUM_PORTS];
  logic [NUM_PORTS-1:0] arb_gnt [NUM_PORTS];
  logic [PORT_W-1:0]    arb_idx [NUM_PORTS];
  logic [NUM_PORTS-1:0] excl;
  logic [NUM_PORTS-1:0] win;
  logic [PORT_W-1:0]    win_idx [NUM_PORTS];
  logic [NUM_PORTS-1:0] win_hot [NUM_PORTS];

  // Inputs that own a locked output are kept out of every unlocked search.
  always_comb begin
    excl = '0;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      cand[o] = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++)
        cand[o][i] = req[i] && (req_dest[i*PORT_W +: PORT_W] == PORT_W'(o));
      if (lock[o]) excl[owner[o]] = 1'b1;
    end
    for (int unsigned o = 0; o < NUM_PORTS; o++)
      arb_req[o] = cand[o] & ~excl;
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_arb
    rr_arbiter #(
      .NUM_PORTS (NUM_PORTS),
      .PORT_W    (PORT_W)
    ) u_arb (
      .req (arb_req[g]),
      .ptr (ptr[g]),
      .gnt (arb_gnt[g]),
      .idx (arb_idx[g])
    );
  end

  always_comb begin
    grant      = '0;
    xbar_valid = '0;
    xbar_sel   = '0;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      win[o]     = 1'b0;
      win_idx[o] = '0;
      win_hot[o] = '0;
      if (lock[o]) begin
        win[o]     = cand[o][owner[o]] && out_ready[o];
        win_idx[o] = owner[o];
        win_hot[o] = NUM_PORTS'(1) << owner[o];
      end else begin
        win[o]     = (|arb_gnt[o]) && out_ready[o];
        win_idx[o] = arb_idx[o];
        win_hot[o] = arb_gnt[o];
      end
      if (win[o] && rst_n) begin
        xbar_valid[o]                 = 1'b1;
        xbar_sel[o*PORT_W +: PORT_W]  = win_idx[o];
        grant                         = grant | win_hot[o];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
        lock[o]  <= 1'b0;
        owner[o] <= '0;
        ptr[o]   <= '0;
      end
    end else begin
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
        if (win[o]) begin
          if (req_tail[win_idx[o]]) begin
            lock[o] <= 1'b0;
            ptr[o]  <= PORT_W'(rr_next(32'(win_idx[o]), NUM_PORTS));
          end else begin
            lock[o]  <= 1'b1;
            owner[o] <= win_idx[o];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: directed scenarios plus random traffic against
// a packet-level reference model.
module tb_switch_allocator;

  localparam int N = 5;
  localparam int W = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_dest = '0;
  logic [N-1:0]   req_tail = '0;
  logic [N-1:0]   out_ready = '0;
  logic [N-1:0]   grant;
  logic [N*W-1:0] xbar_sel;
  logic [N-1:0]   xbar_valid;

  int total = 0;
  int bad   = 0;

  // Reference model: per-output packet owner (-1 when free) and next-priority input.
  int busy_by [N];
  int next_pri [N];
  int dst [N];
  int m_win [N];
  logic [N-1:0]   e_grant;
  logic [N-1:0]   e_valid;
  logic [N*W-1:0] e_sel;

  always #5 clk = ~clk;

  switch_allocator #(
    .NUM_PORTS (N),
    .PORT_W    (W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_dest   (req_dest),
    .req_tail   (req_tail),
    .out_ready  (out_ready),
    .grant      (grant),
    .xbar_sel   (xbar_sel),
    .xbar_valid (xbar_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int o = 0; o < N; o++) begin
      busy_by[o]  = -1;
      next_pri[o] = 0;
    end
  endfunction

  function automatic bit owns_other(input int i);
    for (int p = 0; p < N; p++)
      if (busy_by[p] == i) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_eval();
    int cand;
    e_grant = '0;
    e_valid = '0;
    e_sel   = '0;
    for (int o = 0; o < N; o++) begin
      m_win[o] = -1;
      if (rst_n) begin
        if (busy_by[o] >= 0) begin
          cand = busy_by[o];
          if (req[cand] && dst[cand] == o && out_ready[o]) m_win[o] = cand;
        end else begin
          cand = -1;
          for (int k = 0; k < N; k++) begin
            int i;
            i = (next_pri[o] + k) % N;
            if (cand < 0 && req[i] && dst[i] == o && !owns_other(i)) cand = i;
          end
          if (cand >= 0 && out_ready[o]) m_win[o] = cand;
        end
        if (m_win[o] >= 0) begin
          e_grant[m_win[o]] = 1'b1;
          e_valid[o]        = 1'b1;
          e_sel[o*W +: W]   = W'(m_win[o]);
        end
      end
    end
  endfunction

  function automatic void model_update();
    for (int o = 0; o < N; o++) begin
      if (m_win[o] >= 0) begin
        if (req_tail[m_win[o]]) begin
          busy_by[o]  = -1;
          next_pri[o] = (m_win[o] + 1) % N;
        end else begin
          busy_by[o] = m_win[o];
        end
      end
    end
  endfunction

  task automatic set_in(input logic [N-1:0] r, input logic [N-1:0] t, input logic [N-1:0] rdy);
    req       = r;
    req_tail  = t;
    out_ready = rdy;
    for (int i = 0; i < N; i++) req_dest[i*W +: W] = W'(dst[i]);
  endtask

  // One clock: compare against the model mid-low-phase, advance the model at the edge.
  task automatic step(input string tag);
    #1;
    model_eval();
    chk({tag, ".grant"}, 32'(grant), 32'(e_grant));
    chk({tag, ".valid"}, 32'(xbar_valid), 32'(e_valid));
    chk({tag, ".sel"}, 32'(xbar_sel), 32'(e_sel));
    @(posedge clk);
    if (rst_n) model_update();
    else model_reset();
    @(negedge clk);
  endtask

  initial begin
    int order [5];
    order = '{4, 0, 3, 4, 0};
    for (int i = 0; i < N; i++) dst[i] = 0;
    model_reset();

    // reset / idle
    rst_n = 1'b0;
    set_in(5'b11111, 5'b11111, 5'b11111);
    @(negedge clk);
    #1;
    chk("rst.grant", 32'(grant), 0);
    chk("rst.valid", 32'(xbar_valid), 0);
    step("rst");
    rst_n = 1'b1;
    set_in(5'b00000, 5'b00000, 5'b11111);
    step("idle0");
    step("idle1");

    // single-flit packet 2 -> 4
    dst[2] = 4;
    set_in(5'b00100, 5'b00100, 5'b11111);
    #1;
    chk("single.grant", 32'(grant), 'h04);
    chk("single.sel4", 32'(xbar_sel[14:12]), 2);
    chk("single.valid4", 32'(xbar_valid[4]), 1);
    step("single");
    dst[0] = 4; dst[3] = 4;
    set_in(5'b01001, 5'b01001, 5'b11111);
    #1;
    chk("single.ptr_after", 32'(grant), 'h08);
    step("single2");

    // packet lock on output 3
    dst[0] = 3; dst[1] = 3;
    for (int k = 0; k < 4; k++) begin
      set_in(5'b00011, (k == 3) ? 5'b00011 : 5'b00010, 5'b11111);
      #1;
      chk("lock.owner0", 32'(grant), 'h01);
      step("lock");
    end
    set_in(5'b00010, 5'b00010, 5'b11111);
    #1;
    chk("lock.next", 32'(grant), 'h02);
    chk("lock.sel3", 32'(xbar_sel[11:9]), 1);
    step("lock5");

    // backpressure on output 3 mid-packet
    dst[2] = 3; dst[4] = 3;
    set_in(5'b10100, 5'b10000, 5'b11111);
    #1;
    chk("bp.head", 32'(grant), 'h04);
    step("bp.head");
    for (int k = 0; k < 3; k++) begin
      set_in(5'b10100, 5'b10000, 5'b10111);
      #1;
      chk("bp.stall", 32'(grant), 0);
      step("bp.stall");
    end
    set_in(5'b10100, 5'b10000, 5'b11111);
    #1;
    chk("bp.resume", 32'(grant), 'h04);
    step("bp.resume");
    set_in(5'b10100, 5'b10100, 5'b11111);
    #1;
    chk("bp.tail", 32'(grant), 'h04);
    step("bp.tail");
    set_in(5'b10000, 5'b10000, 5'b11111);
    #1;
    chk("bp.other", 32'(grant), 'h10);
    step("bp.other");

    // round-robin wrap on output 1
    dst[3] = 1;
    set_in(5'b01000, 5'b01000, 5'b11111);
    step("rr.prime");
    dst[0] = 1; dst[4] = 1;
    for (int k = 0; k < 5; k++) begin
      set_in(5'b11001, 5'b11001, 5'b11111);
      #1;
      chk("rr.order", 32'(grant), 32'(1) << order[k]);
      step("rr");
    end

    // parallel outputs, then reset mid-packet
    dst[0] = 1; dst[1] = 2; dst[2] = 3;
    set_in(5'b00111, 5'b00000, 5'b11111);
    #1;
    chk("par.grant", 32'(grant), 'h07);
    step("par");
    set_in(5'b00111, 5'b00000, 5'b11111);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst.grant", 32'(grant), 0);
    chk("midrst.valid", 32'(xbar_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    dst[4] = 3;
    set_in(5'b10000, 5'b00000, 5'b11111);
    #1;
    chk("midrst.newhead", 32'(grant), 'h10);
    step("midrst.new");

    // random traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) dst[i] = $urandom_range(0, 6);
      set_in(N'($urandom), N'($urandom & $urandom), N'(~($urandom & $urandom & $urandom)));
      if (c == 200) begin
        rst_n = 1'b0;
        model_reset();
      end else begin
        rst_n = 1'b1;
      end
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Packet-granular switch allocator for the router crossbar.
- Each input port's Buffer raises a crossbar request (cba_request) toward one output port. This block returns the per-input crossbar grant (cba_grant) and drives the per-output crossbar select.
- Arbitration is round-robin per output port. Once a head flit wins an output, that output stays locked to the winning input until its TAIL flit is granted, so packets never interleave on an output.

Parameters:
- NUM_PORTS, 5, number of router ports; applies to both inputs and outputs (N, S, E, W, Local).
- PORT_W, 3, width of an encoded port index; must satisfy 2^PORT_W >= NUM_PORTS.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- req, input, NUM_PORTS, per-input crossbar request; driven by each Buffer's cba_request.
- req_dest, input, NUM_PORTS*PORT_W, per-input destination output index from route computation; slice i = [i*PORT_W +: PORT_W].
- req_tail, input, NUM_PORTS, per-input flag: the flit at the head of the granted VC is TAIL (flit type bits [57:55] == 3'b010).
- out_ready, input, NUM_PORTS, per-output flag: downstream can accept a flit this cycle (a credit is available).
- grant, output, NUM_PORTS, per-input crossbar grant; drives each Buffer's cba_grant.
- xbar_sel, output, NUM_PORTS*PORT_W, per-output index of the selected input.
- xbar_valid, output, NUM_PORTS, per-output flag: a flit traverses the crossbar this cycle.

Behaviour:
- One clock domain; rst_n is asynchronous, active-low.
- Reset state:
  - lock[o] = 0, owner[o] = 0, ptr[o] = 0 for every output o.
  - grant, xbar_valid and xbar_sel are forced to 0 while rst_n = 0.
- Latency:
  - grant, xbar_sel and xbar_valid are combinational from the current inputs and registered state, giving 0-cycle request-to-grant. The Buffer dequeues in the same cycle.
  - lock, owner and ptr update on the rising edge.
- Candidates for output o: cand[o][i] = req[i] && (req_dest[i] == o). An input with req_dest >= NUM_PORTS is never a candidate.
- Locked output (lock[o] = 1):
  - Only the owner may win: win = cand[o][owner[o]] && out_ready[o].
  - Other candidates wait.
  - If the owner requests a different destination, output o grants no one. That output is still arbitrated normally.
- Unlocked output (lock[o] = 0):
  - Round-robin search over i = ptr[o], ptr[o]+1, ... modulo NUM_PORTS.
  - The first candidate found wins, but only if out_ready[o] = 1.
  - Any input that is the owner of another locked output is excluded from the search.
- Outputs for a winner w on output o:
  - xbar_valid[o] = 1 and xbar_sel[o] = w.
  - grant[w] = 1.
  - grant is the OR over all outputs; each input has a single destination, so it receives at most one grant.
- State update on a win:
  - req_tail[w] = 0: lock[o] <= 1, owner[o] <= w. ptr is unchanged.
  - req_tail[w] = 1: lock[o] <= 0 and ptr[o] <= (w == NUM_PORTS-1) ? 0 : w+1. This covers both single-flit packets and the tail of a locked packet.
- No win on output o: lock, owner and ptr hold. A stall on out_ready = 0 keeps the lock.
- Fairness: ptr advances per packet, not per flit. Starvation is bounded to NUM_PORTS-1 packets.
- Outputs are independent: all NUM_PORTS outputs may grant in the same cycle.
- Reset asserted mid-packet: all locks clear immediately; packets that are partially sent are not recovered by this block.

Decomposition:
- Shared package noc_pkg:
  - NUM_PORTS, PORT_W.
  - Port index constants PORT_N/S/E/W/L.
  - Flit type constants FLIT_HEAD = 3'b000, FLIT_BODY = 3'b001, FLIT_TAIL = 3'b010.
  - Flit type field bounds 57:55.
- Sub-module rr_arbiter, instantiated once per output:
  - Combinational NUM_PORTS-wide request vector plus pointer in.
  - One-hot winner and encoded index out.
  - switch_allocator owns the lock, owner and ptr registers.

Test Plan:
1. Reset / idle: rst_n = 0 with req = 5'b11111 -> grant = 0 and xbar_valid = 0. After release with req = 0 -> all outputs stay 0.
2. Single-flit packet: req[2] = 1, dest 4, tail = 1, out_ready = all 1 -> same cycle grant = 5'b00100, xbar_sel[4] = 2, xbar_valid[4] = 1. Next cycle ptr[4] = 3 and lock[4] = 0.
3. Packet lock:
   - Inputs 0 and 1 both target output 3 with ptr = 0; input 0 sends HEAD, BODY, BODY, TAIL.
   - Required: grant[0] for 4 consecutive cycles and grant[1] = 0 throughout.
   - Cycle 5: grant[1] = 1 and xbar_sel[3] = 1.
4. Backpressure: out_ready[3] drops mid-packet for 3 cycles -> grant = 0 on output 3 and lock held. On recovery the same owner resumes before a competing input 4.
5. Round-robin wrap: inputs 0, 3 and 4 send repeated single-flit packets to output 1 with ptr = 4 -> win order 4, 0, 3, 4, 0.
6. Parallel outputs and reset:
   - Inputs 0→1, 1→2, 2→3 in the same cycle -> grant = 5'b00111.
   - Assert rst_n low mid-packet -> grant drops immediately; after release, a new head on another input wins the formerly locked output.
